// File: rtl/video_pkg.sv
// Shared types and defaults for the pixel fetch path.
package video_pkg;
  localparam int PIX_W_DEF = 16;
  localparam logic [PIX_W_DEF-1:0] UFLOW_COLOR_DEF = 16'hF81F;
  localparam logic [1:0] DISCARD_MAX = 2'd3;

  typedef logic [PIX_W_DEF-1:0] pixel_t;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DONE
  } fetch_state_t;
endpackage

// File: rtl/video_dot_strobe.sv
// Rising-edge detector on the dot clock level: one clk-wide strobe per dot.
module video_dot_strobe (
  input  logic clk,
  input  logic rst_n,
  input  logic i_dotclk,
  output logic o_strobe
);
  logic r_dotclk_q;

  // Resets high so a dotclk already high at reset release is not taken as a new dot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_dotclk_q <= 1'b1;
    else        r_dotclk_q <= i_dotclk;
  end

  assign o_strobe = i_dotclk & ~r_dotclk_q;
endmodule

// File: rtl/video_pixel_fetch.sv
// Converts timing-generator dots into framebuffer reads and emits one registered pixel
// per dot, exactly one dot period after the dot was presented.
module video_pixel_fetch
  import video_pkg::*;
#(
  parameter int DOTCLK_DIV = 10,
  parameter int H_ACTIVE = 240,
  parameter int V_ACTIVE = 320,
  parameter int H_BITS = 9,
  parameter int V_BITS = 9,
  parameter int ADDR_W = 17,
  parameter int PIX_W = PIX_W_DEF,
  parameter logic [PIX_W-1:0] UFLOW_COLOR = UFLOW_COLOR_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              dotclk,
  input  logic              hsync,
  input  logic              vsync,
  input  logic              active,
  input  logic [H_BITS-1:0] pos_h,
  input  logic [V_BITS-1:0] pos_v,
  output logic              fb_req_valid,
  input  logic              fb_req_ready,
  output logic [ADDR_W-1:0] fb_req_addr,
  input  logic              fb_rsp_valid,
  input  logic [PIX_W-1:0]  fb_rsp_data,
  output logic [PIX_W-1:0]  pix_rgb,
  output logic              pix_hsync,
  output logic              pix_vsync,
  output logic              pix_de,
  output logic              underflow,
  input  logic              uflow_clr,
  output fetch_state_t      dbg_state
);
  if (DOTCLK_DIV < 4) begin : g_div_chk
    $error("DOTCLK_DIV too small for a fetch to complete inside one dot");
  end
  if (longint'(H_ACTIVE) * longint'(V_ACTIVE) > (longint'(1) << ADDR_W)) begin : g_addr_chk
    $error("ADDR_W too narrow for H_ACTIVE*V_ACTIVE");
  end

  logic              w_strobe;
  logic              w_miss;
  logic              w_accept;
  logic              w_disc_dec;
  logic              w_uflow_set;
  logic [1:0]        w_disc_next;
  logic [ADDR_W-1:0] w_addr;

  fetch_state_t      r_state;
  logic              r_req_valid;
  logic              r_orphan;
  logic [ADDR_W-1:0] r_addr;
  logic [PIX_W-1:0]  r_data;
  logic [1:0]        r_discard;
  logic              r_hs, r_vs, r_act;
  logic [PIX_W-1:0]  r_pix_rgb;
  logic              r_pix_hs, r_pix_vs, r_pix_de;
  logic              r_uflow;

  video_dot_strobe u_strobe (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_dotclk (dotclk),
    .o_strobe (w_strobe)
  );

  assign w_addr = ADDR_W'(pos_v) * ADDR_W'(H_ACTIVE) + ADDR_W'(pos_h);

  // Request handshake: fb_req_valid rises only from IDLE/DONE at a strobe and stays high
  // with fb_req_addr frozen until a clk where fb_req_ready is also high (the transfer).
  // Each transferred request returns exactly one fb_rsp_valid, in order.
  assign w_accept    = r_req_valid & fb_req_ready;
  // A fetch still owed when its dot slot closes; an orphaned REQ was already counted.
  assign w_miss      = w_strobe & ((r_state == WAIT) | ((r_state == REQ) & ~r_orphan));
  assign w_disc_dec  = fb_rsp_valid & ((r_discard != 2'd0) | (w_miss & (r_state == WAIT)));
  assign w_uflow_set = w_strobe & r_act & (r_state != DONE);

  always_comb begin
    w_disc_next = r_discard;
    if (w_miss && (r_discard != DISCARD_MAX)) w_disc_next = w_disc_next + 2'd1;
    if (w_disc_dec) w_disc_next = w_disc_next - 2'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_req_valid <= 1'b0;
      r_orphan    <= 1'b0;
      r_addr      <= '0;
      r_data      <= '0;
      r_discard   <= '0;
      r_hs        <= 1'b1;
      r_vs        <= 1'b1;
      r_act       <= 1'b0;
      r_pix_rgb   <= '0;
      r_pix_hs    <= 1'b1;
      r_pix_vs    <= 1'b1;
      r_pix_de    <= 1'b0;
      r_uflow     <= 1'b0;
    end else begin
      r_discard <= w_disc_next;
      if (w_uflow_set)    r_uflow <= 1'b1;
      else if (uflow_clr) r_uflow <= 1'b0;

      if (w_strobe) begin
        r_pix_hs  <= r_hs;
        r_pix_vs  <= r_vs;
        r_pix_de  <= r_act;
        r_pix_rgb <= !r_act ? '0 : ((r_state == DONE) ? r_data : UFLOW_COLOR);
        r_hs      <= hsync;
        r_vs      <= vsync;
        r_act     <= active;
      end

      case (r_state)
        IDLE, DONE: begin
          if (w_strobe) begin
            if (active && (r_discard == 2'd0)) begin
              r_addr      <= w_addr;
              r_req_valid <= 1'b1;
              r_state     <= REQ;
            end else begin
              r_state <= IDLE;
            end
          end
        end
        REQ: begin
          if (w_accept) begin
            r_req_valid <= 1'b0;
            r_orphan    <= 1'b0;
            r_state     <= (r_orphan || w_strobe) ? IDLE : WAIT;
          end else if (w_strobe) begin
            r_orphan <= 1'b1;
          end
        end
        WAIT: begin
          if (w_strobe) begin
            r_state <= IDLE;
          end else if (fb_rsp_valid) begin
            r_data  <= fb_rsp_data;
            r_state <= DONE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign fb_req_valid = r_req_valid;
  assign fb_req_addr  = r_addr;
  assign pix_rgb      = r_pix_rgb;
  assign pix_hsync    = r_pix_hs;
  assign pix_vsync    = r_pix_vs;
  assign pix_de       = r_pix_de;
  assign underflow    = r_uflow;
  assign dbg_state    = r_state;
endmodule

// File: tb/tb_video_pixel_fetch.sv
// Randomized scoreboard bench for video_pixel_fetch with a latency-configurable memory model.
module tb_video_pixel_fetch;
  import video_pkg::*;

  localparam int W = 19;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        dotclk = 1'b0;
  logic        hsync = 1'b1;
  logic        vsync = 1'b1;
  logic        active = 1'b0;
  logic [8:0]  pos_h = '0;
  logic [8:0]  pos_v = '0;
  logic        fb_req_valid;
  logic        fb_req_ready = 1'b1;
  logic [16:0] fb_req_addr;
  logic        fb_rsp_valid = 1'b0;
  logic [15:0] fb_rsp_data = '0;
  logic [15:0] pix_rgb;
  logic        pix_hsync, pix_vsync, pix_de, underflow;
  logic        uflow_clr = 1'b0;
  fetch_state_t dbg_state;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_q[$];
  logic [16:0]  addr_q[$];

  int          cnt_q[$];
  logic [15:0] dat_q[$];
  int          lat_min = 2, lat_max = 2, stall_max = 0, stall_ovr = -1, stall_left = 0;
  bit          in_req = 0, hold_pend = 0, no_req = 0, addr_chk = 1;
  logic [16:0] hold_addr = '0;
  bit          mon_prev = 1'b1;

  video_pixel_fetch dut (
    .clk(clk), .rst_n(rst_n), .dotclk(dotclk), .hsync(hsync), .vsync(vsync),
    .active(active), .pos_h(pos_h), .pos_v(pos_v),
    .fb_req_valid(fb_req_valid), .fb_req_ready(fb_req_ready), .fb_req_addr(fb_req_addr),
    .fb_rsp_valid(fb_rsp_valid), .fb_rsp_data(fb_rsp_data),
    .pix_rgb(pix_rgb), .pix_hsync(pix_hsync), .pix_vsync(pix_vsync), .pix_de(pix_de),
    .underflow(underflow), .uflow_clr(uflow_clr), .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", name, act, exp);
    end
  endtask

  // ---------------- memory model ----------------
  always @(negedge clk) begin
    if (!rst_n) begin
      cnt_q.delete();
      dat_q.delete();
      fb_rsp_valid = 1'b0;
      fb_req_ready = 1'b1;
      in_req = 0;
      hold_pend = 0;
    end else begin
      fb_rsp_valid = 1'b0;
      foreach (cnt_q[i]) cnt_q[i] = cnt_q[i] - 1;
      if (cnt_q.size() > 0 && cnt_q[0] <= 0) begin
        fb_rsp_valid = 1'b1;
        fb_rsp_data  = dat_q.pop_front();
        void'(cnt_q.pop_front());
      end
      if (hold_pend) begin
        check("req_hold_valid", 32'(fb_req_valid), 32'd1);
        check("req_hold_addr", 32'(fb_req_addr), 32'(hold_addr));
        hold_pend = 0;
      end
      if (no_req) check("no_req_after_rst", 32'(fb_req_valid), 32'd0);
      fb_req_ready = 1'b1;
      if (fb_req_valid) begin
        if (!in_req) begin
          in_req = 1;
          stall_left = (stall_ovr >= 0) ? stall_ovr : int'($urandom_range(0, stall_max));
        end
        if (stall_left > 0) begin
          fb_req_ready = 1'b0;
          stall_left--;
          hold_pend = 1;
          hold_addr = fb_req_addr;
        end else begin
          in_req = 0;
          if (addr_chk) begin
            if (addr_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL req_addr_unexpected got %h exp none", fb_req_addr);
            end else begin
              check("req_addr", 32'(fb_req_addr), 32'(addr_q.pop_front()));
            end
          end
          cnt_q.push_back(int'($urandom_range(lat_min, lat_max)));
          dat_q.push_back(fb_req_addr[15:0]);
        end
      end
    end
  end

  // ---------------- output monitor ----------------
  always @(posedge clk) begin
    if (!rst_n) begin
      mon_prev = 1'b1;
    end else if (dotclk && !mon_prev) begin
      mon_prev = 1'b1;
      #1;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pix_unexpected got %h exp none", {pix_de, pix_hsync, pix_vsync, pix_rgb});
      end else begin
        check("pix_out", 32'({pix_de, pix_hsync, pix_vsync, pix_rgb}), 32'(exp_q.pop_front()));
      end
    end else begin
      mon_prev = dotclk;
    end
  end

  // ---------------- driver ----------------
  task automatic drive_dot(input bit act, input int h, input int v, input bit hs, input bit vs,
                           input bit slow, input bit clr);
    logic [16:0] a;
    logic [15:0] rgb;
    a   = 17'(v * 240 + h);
    rgb = act ? (slow ? 16'hF81F : a[15:0]) : 16'h0000;
    exp_q.push_back({act, hs, vs, rgb});
    if (act && addr_chk) addr_q.push_back(a);
    dotclk = 1'b1;
    active = act;
    pos_h  = 9'(h);
    pos_v  = 9'(v);
    hsync  = hs;
    vsync  = vs;
    uflow_clr = clr;
    @(negedge clk);
    uflow_clr = 1'b0;
    repeat (4) @(negedge clk);
    dotclk = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic rand_dot(input bit slow);
    bit a, hs, vs;
    int h, v;
    a  = $urandom_range(0, 9) < 7;
    h  = int'($urandom_range(0, 239));
    v  = int'($urandom_range(0, 319));
    hs = $urandom_range(0, 9) != 0;
    vs = $urandom_range(0, 19) != 0;
    drive_dot(a, h, v, hs, vs, slow, 1'b0);
  endtask

  task automatic reset_mid_wait();
    lat_min = 4; lat_max = 4; stall_max = 0;
    addr_q.push_back(17'(7 * 240 + 9));
    dotclk = 1'b1; active = 1'b1; pos_h = 9'd9; pos_v = 9'd7; hsync = 1'b1; vsync = 1'b1;
    repeat (3) @(negedge clk);
    check("pre_rst_wait", 32'(dbg_state), 32'(WAIT));
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_req_valid", 32'(fb_req_valid), 32'd0);
    check("rst_mid_rgb", 32'(pix_rgb), 32'd0);
    check("rst_mid_syncs_de", 32'({pix_hsync, pix_vsync, pix_de}), 32'b110);
    check("rst_mid_uflow", 32'(underflow), 32'd0);
    check("rst_mid_state", 32'(dbg_state), 32'(IDLE));
    exp_q.delete();
    exp_q.push_back({1'b0, 1'b1, 1'b1, 16'h0000});
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    dotclk = 1'b0;
    active = 1'b0;
    no_req = 1;
    repeat (5) @(negedge clk);
    drive_dot(1'b0, 0, 0, 1'b1, 1'b1, 1'b0, 1'b0);
    no_req = 0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    repeat (3) @(negedge clk);
    check("rst_req_valid", 32'(fb_req_valid), 32'd0);
    check("rst_rgb", 32'(pix_rgb), 32'd0);
    check("rst_hsync", 32'(pix_hsync), 32'd1);
    check("rst_vsync", 32'(pix_vsync), 32'd1);
    check("rst_de", 32'(pix_de), 32'd0);
    check("rst_uflow", 32'(underflow), 32'd0);
    rst_n = 1'b1;
    exp_q.push_back({1'b0, 1'b1, 1'b1, 16'h0000});
    @(negedge clk);

    lat_min = 2; lat_max = 2; stall_max = 0;
    drive_dot(1'b1, 5, 3, 1'b1, 1'b1, 1'b0, 1'b0);
    drive_dot(1'b0, 0, 0, 1'b0, 1'b1, 1'b0, 1'b0);
    drive_dot(1'b0, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
    drive_dot(1'b1, 0, 0, 1'b1, 1'b1, 1'b0, 1'b0);

    stall_ovr = 4;
    drive_dot(1'b1, 239, 319, 1'b1, 1'b1, 1'b0, 1'b0);
    stall_ovr = -1;

    lat_min = 1; lat_max = 4; stall_max = 2;
    for (int i = 0; i < 250; i++) rand_dot(1'b0);
    drive_dot(1'b0, 0, 0, 1'b1, 1'b1, 1'b0, 1'b0);
    check("uflow_clean", 32'(underflow), 32'd0);

    addr_chk = 0;
    lat_min = 12; lat_max = 12; stall_max = 0;
    for (int i = 0; i < 19; i++) rand_dot(1'b1);
    drive_dot(1'b1, 100, 200, 1'b1, 1'b1, 1'b1, 1'b0);
    drive_dot(1'b0, 0, 0, 1'b1, 1'b1, 1'b1, 1'b0);
    check("uflow_set", 32'(underflow), 32'd1);
    drive_dot(1'b0, 0, 0, 1'b1, 1'b1, 1'b1, 1'b1);
    check("uflow_clr_alone", 32'(underflow), 32'd0);
    drive_dot(1'b1, 17, 33, 1'b1, 1'b1, 1'b1, 1'b0);
    drive_dot(1'b0, 0, 0, 1'b1, 1'b1, 1'b1, 1'b1);
    check("uflow_set_wins", 32'(underflow), 32'd1);
    repeat (3) drive_dot(1'b0, 0, 0, 1'b1, 1'b1, 1'b1, 1'b0);
    addr_chk = 1;

    reset_mid_wait();

    lat_min = 1; lat_max = 4; stall_max = 2;
    for (int i = 0; i < 30; i++) rand_dot(1'b0);
    drive_dot(1'b0, 0, 0, 1'b1, 1'b1, 1'b0, 1'b0);
    check("uflow_after_rst", 32'(underflow), 32'd0);
    check("sb_drain", 32'(exp_q.size()), 32'd1);
    check("addr_drain", 32'(addr_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
